// File: rtl/change_dispenser_if.sv
`default_nettype none
// ============================================================================
//  Module   : change_dispenser_if
//  Purpose  : Refund request / completion bundle between the vending
//             controller (master) and the change dispenser (slave).
//  Signals  : req_valid, req_amount     master -> slave  refund request
//             req_ready, busy           slave  -> master flow control
//             done, jam, shortfall      slave  -> master completion status
//  Revision : 1.0  initial release
// ============================================================================
interface change_dispenser_if #(
   parameter int AMT_W = 8
) ();
   logic             req_valid;
   logic             req_ready;
   logic [AMT_W-1:0] req_amount;
   logic             busy;
   logic             done;
   logic             jam;
   logic [AMT_W-1:0] shortfall;

   modport master (
      output req_valid, req_amount,
      input  req_ready, busy, done, jam, shortfall
   );

   modport slave (
      input  req_valid, req_amount,
      output req_ready, busy, done, jam, shortfall
   );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module   : change_dispenser
//  Purpose  : Change-return controller. Accepts a refund amount (nickel units)
//             and ejects quarters/dimes/nickels one at a time, largest coin
//             first, confirming each with the hopper drop sensor. Reports
//             completion, unpaid shortfall and hopper jams.
//  Ports    : clk, rst                 clock, async active-high reset
//             bus (slave)              request / status bundle
//             load, load_q/d/n         inventory load (honoured in IDLE only)
//             eject_q/d/n              one-cycle eject commands
//             coin_sense               drop-sensor pulse
//             inv_q/d/n                current inventory counts
//  Revision : 1.0  initial release
// ============================================================================
module change_dispenser #(
   parameter int AMT_W   = 8,
   parameter int INV_W   = 6,
   parameter int TIMEOUT = 15
) (
   input  wire logic             clk,
   input  wire logic             rst,
   change_dispenser_if.slave     bus,
   input  wire logic             load,
   input  wire logic [INV_W-1:0] load_q,
   input  wire logic [INV_W-1:0] load_d,
   input  wire logic [INV_W-1:0] load_n,
   output logic                  eject_q,
   output logic                  eject_d,
   output logic                  eject_n,
   input  wire logic             coin_sense,
   output logic [INV_W-1:0]      inv_q,
   output logic [INV_W-1:0]      inv_d,
   output logic [INV_W-1:0]      inv_n
);

   localparam int              c_TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_TW-1:0] c_TMAX   = c_TW'(TIMEOUT - 1);

   localparam logic [AMT_W-1:0] c_VAL_Q = AMT_W'(5);
   localparam logic [AMT_W-1:0] c_VAL_D = AMT_W'(2);
   localparam logic [AMT_W-1:0] c_VAL_N = AMT_W'(1);

   localparam logic [1:0] c_SEL_Q = 2'd0;
   localparam logic [1:0] c_SEL_D = 2'd1;
   localparam logic [1:0] c_SEL_N = 2'd2;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PICK   = 3'd1;
   localparam logic [2:0] S_EJECT  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [AMT_W-1:0] r_rem;
   logic [INV_W-1:0] r_inv_q, r_inv_d, r_inv_n;
   logic [1:0]       r_sel;
   logic [c_TW-1:0]  r_timer;
   logic             r_jam;
   logic [AMT_W-1:0] r_shortfall;

   logic             w_pick_ok;
   logic [1:0]       w_pick_sel;
   logic [AMT_W-1:0] w_coin_val;
   logic             w_req_ready, w_busy, w_done;
   logic             w_ej_q, w_ej_d, w_ej_n;

   // Greedy coin choice. Only meaningful when r_rem != 0, so a nickel
   // always fits whenever one is in stock.
   always_comb begin
      w_pick_ok  = 1'b1;
      w_pick_sel = c_SEL_N;
      if (r_rem >= c_VAL_Q && r_inv_q != '0)
         w_pick_sel = c_SEL_Q;
      else if (r_rem >= c_VAL_D && r_inv_d != '0)
         w_pick_sel = c_SEL_D;
      else if (r_inv_n != '0)
         w_pick_sel = c_SEL_N;
      else
         w_pick_ok = 1'b0;
   end

   always_comb begin
      case (r_sel)
         c_SEL_Q: w_coin_val = c_VAL_Q;
         c_SEL_D: w_coin_val = c_VAL_D;
         default: w_coin_val = c_VAL_N;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (bus.req_valid) w_state_nxt = S_PICK;
         S_PICK:   w_state_nxt = (r_rem == '0 || !w_pick_ok) ? S_FINISH : S_EJECT;
         S_EJECT:  w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (coin_sense)
               w_state_nxt = S_PICK;
            else if (r_timer == c_TMAX)
               w_state_nxt = S_FINISH;
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (decoded from state) ----------------
   always_comb begin
      w_req_ready = (r_state == S_IDLE);
      w_busy      = (r_state != S_IDLE);
      w_done      = (r_state == S_FINISH);
      w_ej_q      = (r_state == S_EJECT) && (r_sel == c_SEL_Q);
      w_ej_d      = (r_state == S_EJECT) && (r_sel == c_SEL_D);
      w_ej_n      = (r_state == S_EJECT) && (r_sel == c_SEL_N);
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem       <= '0;
         r_inv_q     <= '0;
         r_inv_d     <= '0;
         r_inv_n     <= '0;
         r_sel       <= c_SEL_Q;
         r_timer     <= '0;
         r_jam       <= 1'b0;
         r_shortfall <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Load and request may coincide; PICK then sees the new stock.
               if (load) begin
                  r_inv_q <= load_q;
                  r_inv_d <= load_d;
                  r_inv_n <= load_n;
               end
               if (bus.req_valid) begin
                  r_rem       <= bus.req_amount;
                  r_jam       <= 1'b0;
                  r_shortfall <= '0;
               end
            end
            S_PICK: begin
               if (r_rem != '0) begin
                  if (w_pick_ok)
                     r_sel <= w_pick_sel;
                  else
                     r_shortfall <= r_rem;
               end
            end
            S_EJECT: r_timer <= '0;
            S_WAIT: begin
               // A pulse on the final cycle still counts as a good drop.
               if (coin_sense) begin
                  r_rem <= r_rem - w_coin_val;
                  case (r_sel)
                     c_SEL_Q: r_inv_q <= r_inv_q - 1'b1;
                     c_SEL_D: r_inv_d <= r_inv_d - 1'b1;
                     default: r_inv_n <= r_inv_n - 1'b1;
                  endcase
               end else if (r_timer == c_TMAX) begin
                  r_jam       <= 1'b1;
                  r_shortfall <= r_rem;
               end else begin
                  r_timer <= r_timer + c_TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.busy      = w_busy;
   assign bus.done      = w_done;
   assign bus.jam       = r_jam;
   assign bus.shortfall = r_shortfall;
   assign eject_q       = w_ej_q;
   assign eject_d       = w_ej_d;
   assign eject_n       = w_ej_n;
   assign inv_q         = r_inv_q;
   assign inv_d         = r_inv_d;
   assign inv_n         = r_inv_n;

endmodule
`default_nettype wire
